// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Merges an asynchronous reset request (req_a, synchronized) with
//            a synchronous software request (sw_req). Holds all downstream
//            resets for HOLD_CYCLES request-free cycles, then releases the
//            outputs one per STEP_CYCLES in ascending index order. Reports
//            busy / done status and counts in-service (RUN -> HOLD) events.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic               sw_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               done_pulse,
  output logic [7:0]         req_count
);

  // Counter widths; a single-value range still needs one bit.
  localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int c_IDX_W  = (NUM_OUT > 1)     ? $clog2(NUM_OUT)     : 1;

  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
  localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_OUT - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
  localparam logic [7:0]          c_CNT_MAX   = 8'hFF;
  localparam logic [7:0]          c_CNT_ONE   = 8'h01;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;
  logic                   w_rq;

  state_t                 r_state;
  logic [c_HOLD_W-1:0]    r_hold_cnt;
  logic [c_STEP_W-1:0]    r_step_cnt;
  logic [c_IDX_W-1:0]     r_idx;
  logic [NUM_OUT-1:0]     r_rst_out;
  logic                   r_busy;
  logic                   r_done_pulse;
  logic [7:0]             r_req_count;

  // Synchronizer chain for the asynchronous request; stage 0 samples req_a.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_a};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_rq    = w_req_s | sw_req;

  // Sequencing FSM: any request returns to HOLD with every output asserted;
  // request-free cycles walk through HOLD, then RELEASE, then RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_hold_cnt   <= '0;
      r_step_cnt   <= '0;
      r_idx        <= '0;
      r_rst_out    <= '1;
      r_busy       <= 1'b1;
      r_done_pulse <= 1'b0;
      r_req_count  <= '0;
    end else begin
      r_done_pulse <= 1'b0;
      case (r_state)
        ST_HOLD: begin
          r_rst_out <= '1;
          r_busy    <= 1'b1;
          if (w_rq) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            r_state    <= ST_RELEASE;
            r_step_cnt <= '0;
            r_idx      <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
          end
        end

        ST_RELEASE: begin
          r_busy <= 1'b1;
          if (w_rq) begin
            // Abort: re-assert bits already released, no count, no done.
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_rst_out  <= '1;
          end else if (r_step_cnt == c_STEP_LAST) begin
            r_rst_out[r_idx] <= 1'b0;
            r_step_cnt       <= '0;
            if (r_idx == c_IDX_LAST) begin
              r_state      <= ST_RUN;
              r_busy       <= 1'b0;
              r_done_pulse <= 1'b1;
            end else begin
              r_idx <= r_idx + c_IDX_ONE;
            end
          end else begin
            r_step_cnt <= r_step_cnt + c_STEP_ONE;
          end
        end

        ST_RUN: begin
          if (w_rq) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_rst_out  <= '1;
            r_busy     <= 1'b1;
            if (r_req_count != c_CNT_MAX) begin
              r_req_count <= r_req_count + c_CNT_ONE;
            end
          end else begin
            r_rst_out <= '0;
            r_busy    <= 1'b0;
          end
        end

        default: begin
          r_state    <= ST_HOLD;
          r_hold_cnt <= '0;
          r_rst_out  <= '1;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  assign rst_out    = r_rst_out;
  assign busy       = r_busy;
  assign done_pulse = r_done_pulse;
  assign req_count  = r_req_count;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. A reference model
//            derives expected outputs from the count of consecutive
//            request-free edges; a monitor compares them every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int c_NUM_OUT = 4;
  localparam int c_SYNC    = 2;
  localparam int c_HOLD    = 16;
  localparam int c_STEP    = 4;
  localparam int c_TOTAL   = c_HOLD + c_NUM_OUT * c_STEP;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_a;
  logic                 sw_req;
  logic [c_NUM_OUT-1:0] rst_out;
  logic                 busy;
  logic                 done_pulse;
  logic [7:0]           req_count;

  typedef struct packed {
    logic [c_NUM_OUT-1:0] rst;
    logic                 busy;
    logic                 done;
    logic [7:0]           cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state
  int              quiet = 0;   // consecutive request-free edges, capped
  int              cnt   = 0;
  logic [c_SYNC-1:0] hist = '0; // req_a as sampled on previous edges

  reset_sequencer #(
    .NUM_OUT    (c_NUM_OUT),
    .SYNC_STAGES(c_SYNC),
    .HOLD_CYCLES(c_HOLD),
    .STEP_CYCLES(c_STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .sw_req    (sw_req),
    .rst_out   (rst_out),
    .busy      (busy),
    .done_pulse(done_pulse),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Model: at each edge, apply the request rules to the quiet-run length and
  // push the outputs the DUT must show after this edge.
  always @(posedge clk) begin
    exp_t e;
    logic rq;
    cyc++;
    if (reset) begin
      quiet = 0;
      cnt   = 0;
      hist  = '0;
    end else begin
      rq   = hist[c_SYNC-1] | sw_req;
      hist = {hist[c_SYNC-2:0], req_a};
      if (rq) begin
        if (quiet >= c_TOTAL && cnt < 255) cnt++;
        quiet = 0;
      end else if (quiet <= c_TOTAL) begin
        quiet++;
      end
    end
    for (int k = 0; k < c_NUM_OUT; k++)
      e.rst[k] = (quiet < c_HOLD + (k + 1) * c_STEP);
    e.busy = (quiet < c_TOTAL);
    e.done = (quiet == c_TOTAL);
    e.cnt  = 8'(cnt);
    exp_q.push_back(e);
  end

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_rst_out", 32'(rst_out), 32'(e.rst));
        check("sb_busy", 32'(busy), 32'(e.busy));
        check("sb_done_pulse", 32'(done_pulse), 32'(e.done));
        check("sb_req_count", 32'(req_count), 32'(e.cnt));
      end
    end
  end

  task automatic wait_run();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_run_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_sw();
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
  endtask

  initial begin
    logic [3:0] er;
    int n;
    reset  = 1'b1;
    req_a  = 1'b0;
    sw_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rst_out", 32'(rst_out), 32'hF);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_req_count", 32'(req_count), 32'd0);
    reset = 1'b0;

    // Power-up timeline, absolute edge numbers
    for (int e = 0; e < 36; e++) begin
      @(negedge clk);
      er = (e < 19) ? 4'hF : (e < 23) ? 4'hE : (e < 27) ? 4'hC : (e < 31) ? 4'h8 : 4'h0;
      check("pwr_rst_out", 32'(rst_out), 32'(er));
      check("pwr_done", 32'(done_pulse), 32'(e == 31));
      check("pwr_busy", 32'(busy), 32'(e < 31));
    end

    // Software request in RUN
    pulse_sw();
    check("sw_run_rst_out", 32'(rst_out), 32'hF);
    check("sw_run_count", 32'(req_count), 32'd1);
    for (int e = 1; e < 32; e++) @(negedge clk);
    check("sw_run_not_yet", 32'(rst_out), 32'h8);
    @(negedge clk);
    check("sw_run_released", 32'(rst_out), 32'h0);

    // Abort mid-RELEASE once rst_out reads 1100
    pulse_sw();
    n = 0;
    while (rst_out !== 4'hC && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_1100", 32'(n < 100), 32'd1);
    pulse_sw();
    check("abort_rst_out", 32'(rst_out), 32'hF);
    check("abort_count", 32'(req_count), 32'd2);
    wait_run();

    // req_a assert latency from RUN, then held 50 cycles
    req_a = 1'b1;
    @(negedge clk);
    check("req_a_lat1", 32'(rst_out), 32'h0);
    @(negedge clk);
    check("req_a_lat2", 32'(rst_out), 32'h0);
    @(negedge clk);
    check("req_a_lat3", 32'(rst_out), 32'hF);
    repeat (47) @(negedge clk);
    req_a = 1'b0;
    wait_run();

    // Glitch between edges (never sampled), then one straddling an edge
    #1 req_a = 1'b1;
    #1 req_a = 1'b0;
    repeat (5) @(negedge clk);
    #4 req_a = 1'b1;
    #2 req_a = 1'b0;
    @(negedge clk);
    wait_run();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sw_req = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) req_a = ~req_a;
      reset = ($urandom_range(0, 999) == 0);
    end
    sw_req = 1'b0;
    req_a  = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    wait_run();

    // Saturation of req_count
    for (int i = 0; i < 300; i++) begin
      pulse_sw();
      wait_run();
    end
    check("sat_count", 32'(req_count), 32'd255);

    // Reset in RUN with req_count = 5
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_run();
    for (int i = 0; i < 5; i++) begin
      pulse_sw();
      wait_run();
    end
    check("pre_reset_count", 32'(req_count), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_rst_out", 32'(rst_out), 32'hF);
    check("mid_reset_busy", 32'(busy), 32'd1);
    check("mid_reset_done", 32'(done_pulse), 32'd0);
    check("mid_reset_count", 32'(req_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
